// File: rtl/sync_mod_counter_pkg.sv
// Shared direction encodings and modulo next-value helper for the synchronous counter.
package sync_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wrapped next value: explicit wrap at both ends, never natural overflow.
    function automatic logic [31:0] mod_next(input logic [31:0] q,
                                             input logic        up,
                                             input logic [31:0] modulus);
        logic [31:0] last;
        last = modulus - 32'd1;
        if (up == DIR_UP) begin
            mod_next = (q == last) ? 32'd0 : q + 32'd1;
        end else begin
            mod_next = (q == 32'd0) ? last : q - 32'd1;
        end
    endfunction

endpackage

// File: rtl/sync_mod_counter_if.sv
// Control/status bundle between a counter and the logic that drives it.
interface sync_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrap;

    modport master (output en, up_dn, load, load_val, input Q, tc, wrap);
    modport slave  (input en, up_dn, load, load_val, output Q, tc, wrap);
endinterface

// File: rtl/sync_mod_counter_next.sv
// Combinational next count and boundary detection.
// SYNC_MOD_COUNTER_SAT_EN selects saturation at the boundaries instead of wrapping.
module sync_counter_next
    import sync_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_at_max,
    output logic             o_at_min
);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_wrapped;

    assign w_at_max  = (i_q == Q_MAX);
    assign w_at_min  = (i_q == '0);
    assign w_wrapped = WIDTH'(mod_next(32'(i_q), i_up, 32'(MODULUS)));
    assign o_at_max  = w_at_max;
    assign o_at_min  = w_at_min;

`ifdef SYNC_MOD_COUNTER_SAT_EN
    logic w_at_limit;
    // Hold at the boundary in the direction of travel.
    assign w_at_limit = (i_up == DIR_UP) ? w_at_max : w_at_min;
    assign o_next_q   = w_at_limit ? i_q : w_wrapped;
`else
    assign o_next_q = w_wrapped;
`endif

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-N up/down counter with load clamp, cascade tc and wrap pulse.
// SYNC_MOD_COUNTER_SAT_EN: saturate at the boundaries and tie wrap low.
module sync_mod_counter
    import sync_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    sync_mod_counter_if.slave        bus
);
    localparam longint unsigned  MOD_LIMIT = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH == 0 || WIDTH > 32 || MODULUS < 2 || 64'(MODULUS) > MOD_LIMIT) begin : g_bad_params
            $error("sync_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_load_q;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_at_limit;
    logic             w_wrap_evt;

    sync_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_q      (r_q),
        .i_up     (bus.up_dn),
        .o_next_q (w_next_q),
        .o_at_max (w_at_max),
        .o_at_min (w_at_min)
    );

    assign w_at_limit = (bus.up_dn == DIR_UP) ? w_at_max : w_at_min;
    assign w_load_q   = (bus.load_val > Q_MAX) ? Q_MAX : bus.load_val;

`ifdef SYNC_MOD_COUNTER_SAT_EN
    assign w_wrap_evt = 1'b0;
`else
    assign w_wrap_evt = w_at_limit;
`endif

    // Priority: clear > load > count enable.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
        end else if (bus.en) begin
            r_q    <= w_next_q;
            r_wrap <= w_wrap_evt;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.Q    = r_q;
    assign bus.wrap = r_wrap;
    // Zero-latency so a cascaded stage advances on the same edge.
    assign bus.tc   = bus.en & ~bus.load & w_at_limit;

endmodule
